// File: rtl/gpio_pud_scanner.sv
// Pull-up/pull-down pad self-test sequencer: per masked channel, pull down, pull up, release, sample.
// Latency: serial NUM_IO + k*(2*SETTLE_CYCLES+1) cycles to DONE, parallel 2*SETTLE_CYCLES+1 cycles.
// Backpressure: none; start is only honoured in IDLE, all other start pulses are dropped.
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   start                 begin a scan (IDLE only)
//   parallel, chan_mask   scan mode and channel set, latched at start
//   pad_in                raw pad inputs, asynchronous, double-synchronized internally
//   pull_en, pull_up      pad pull controls (registered)
//   busy, done, pass      scan status; pass valid from done until the next start
//   fail_mask             sticky per-channel failures of the current/last scan
//   cur_chan              channel under test (0 in parallel mode)
//   checkpoint            6-bit progress code matching the firmware checkbits
module gpio_pud_scanner #(
   parameter int NUM_IO        = 38,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        parallel,
   input  logic [NUM_IO-1:0]           chan_mask,
   input  logic [NUM_IO-1:0]           pad_in,
   output logic [NUM_IO-1:0]           pull_en,
   output logic [NUM_IO-1:0]           pull_up,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [NUM_IO-1:0]           fail_mask,
   output logic [$clog2(NUM_IO)-1:0]   cur_chan,
   output logic [5:0]                  checkpoint
);

   localparam int CW  = $clog2(NUM_IO);
   localparam int SCW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [SCW-1:0]    SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]     LAST_CHAN   = CW'(NUM_IO - 1);
   localparam logic [NUM_IO-1:0] ONE_LSB     = {{(NUM_IO-1){1'b0}}, 1'b1};

   localparam logic [5:0] CP_SCAN = 6'h30;
   localparam logic [5:0] CP_PD   = 6'h31;
   localparam logic [5:0] CP_PU   = 6'h32;
   localparam logic [5:0] CP_REL  = 6'h33;
   localparam logic [5:0] CP_PASS = 6'h34;
   localparam logic [5:0] CP_FAIL = 6'h3F;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_PD, S_PU, S_REL, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [NUM_IO-1:0] pad_meta, pad_sync;
   logic [NUM_IO-1:0] mask_q, mask_nxt;
   logic              par_q, par_nxt;
   logic [CW-1:0]     cur_nxt;
   logic [SCW-1:0]    settle_cnt, settle_nxt;
   logic [NUM_IO-1:0] target_nxt;
   logic [NUM_IO-1:0] pull_en_nxt, pull_up_nxt, fail_nxt;
   logic              busy_nxt, done_nxt, pass_nxt;
   logic [5:0]        cp_nxt;
   logic              settle_last;
   logic              start_acc;

   assign settle_last = (settle_cnt == '0);
   assign start_acc   = (state == S_IDLE) && start;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = parallel ? S_PD : S_SCAN;
         S_SCAN: begin
            if (mask_q[cur_chan])          state_nxt = S_PD;
            else if (cur_chan == LAST_CHAN) state_nxt = S_DONE;
         end
         S_PD:   if (settle_last) state_nxt = S_PU;
         S_PU:   if (settle_last) state_nxt = S_REL;
         S_REL:  state_nxt = (par_q || cur_chan == LAST_CHAN) ? S_DONE : S_SCAN;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values of every registered output, keyed on the
   // state being entered so pulls and codes change on the first cycle of a phase.
   always_comb begin
      mask_nxt   = mask_q;
      par_nxt    = par_q;
      cur_nxt    = cur_chan;
      fail_nxt   = fail_mask;
      pass_nxt   = pass;
      cp_nxt     = checkpoint;
      settle_nxt = settle_cnt;

      if (start_acc) begin
         mask_nxt = chan_mask;
         par_nxt  = parallel;
         cur_nxt  = '0;
         fail_nxt = '0;
         pass_nxt = 1'b0;
      end

      // Serial stepping: leaving SCAN or REL for another SCAN moves to the next channel.
      if ((state == S_SCAN || state == S_REL) && state_nxt == S_SCAN)
         cur_nxt = cur_chan + CW'(1);

      // pull_en holds exactly the target set while in PD/PU, so it doubles as the sample mask.
      if (state == S_PD && settle_last) fail_nxt = fail_mask | (pull_en & pad_sync);
      if (state == S_PU && settle_last) fail_nxt = fail_mask | (pull_en & ~pad_sync);

      if (state_nxt != state && (state_nxt == S_PD || state_nxt == S_PU))
         settle_nxt = SETTLE_LOAD;
      else if (!settle_last)
         settle_nxt = settle_cnt - SCW'(1);

      target_nxt  = par_nxt ? mask_nxt : (mask_nxt & (ONE_LSB << cur_nxt));
      pull_en_nxt = (state_nxt == S_PD || state_nxt == S_PU) ? target_nxt : '0;
      pull_up_nxt = (state_nxt == S_PU) ? target_nxt : '0;
      busy_nxt    = (state_nxt == S_SCAN) || (state_nxt == S_PD) ||
                    (state_nxt == S_PU)   || (state_nxt == S_REL);
      done_nxt    = (state_nxt == S_DONE);

      case (state_nxt)
         S_SCAN: cp_nxt = CP_SCAN;
         S_PD:   cp_nxt = CP_PD;
         S_PU:   cp_nxt = CP_PU;
         S_REL:  cp_nxt = CP_REL;
         S_DONE: cp_nxt = (fail_nxt == '0) ? CP_PASS : CP_FAIL;
         default: cp_nxt = checkpoint;
      endcase
      if (state_nxt == S_DONE) pass_nxt = (fail_nxt == '0);
   end

   // Datapath and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         pad_meta   <= '0;
         pad_sync   <= '0;
         mask_q     <= '0;
         par_q      <= 1'b0;
         cur_chan   <= '0;
         settle_cnt <= '0;
         fail_mask  <= '0;
         pass       <= 1'b0;
         checkpoint <= 6'h00;
         pull_en    <= '0;
         pull_up    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         pad_meta   <= pad_in;
         pad_sync   <= pad_meta;
         mask_q     <= mask_nxt;
         par_q      <= par_nxt;
         cur_chan   <= cur_nxt;
         settle_cnt <= settle_nxt;
         fail_mask  <= fail_nxt;
         pass       <= pass_nxt;
         checkpoint <= cp_nxt;
         pull_en    <= pull_en_nxt;
         pull_up    <= pull_up_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_gpio_pud_scanner.sv
// Self-checking bench for gpio_pud_scanner with a pad model and a per-cycle expected trace.
// Latency: expectations are cycle-exact from the start edge to the cycle after DONE.
// Backpressure: none; start/chan_mask are optionally perturbed mid-scan.
module tb_gpio_pud_scanner;

   localparam int N = 8;
   localparam int S = 4;

   typedef logic [26:0] obs_t;   // {busy, done, cur_chan, pull_en, pull_up, checkpoint}

   logic         clock = 1'b0;
   logic         reset, start, parallel;
   logic [N-1:0] chan_mask, pad_in;
   logic [N-1:0] pull_en, pull_up, fail_mask;
   logic         busy, done, pass;
   logic [2:0]   cur_chan;
   logic [5:0]   checkpoint;

   logic [N-1:0] stuck0, stuck1;
   int           checks = 0;
   int           errors = 0;

   always #5 clock = ~clock;

   gpio_pud_scanner #(.NUM_IO(N), .SETTLE_CYCLES(S)) dut (
      .clock(clock), .reset(reset), .start(start), .parallel(parallel),
      .chan_mask(chan_mask), .pad_in(pad_in), .pull_en(pull_en), .pull_up(pull_up),
      .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
      .cur_chan(cur_chan), .checkpoint(checkpoint)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic obs_t pack(input logic b, input logic d, input logic [2:0] c,
                                 input logic [N-1:0] pe, input logic [N-1:0] pu,
                                 input logic [5:0] cp);
      return {b, d, c, pe, pu, cp};
   endfunction

   // Pads: stuck pins ignore pulls, healthy pins follow the applied pull, floating pins are noise.
   task automatic drive_pad();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) begin
         if (stuck0[c])       v[c] = 1'b0;
         else if (stuck1[c])  v[c] = 1'b1;
         else if (pull_en[c]) v[c] = pull_up[c];
         else                 v[c] = 1'($urandom_range(0, 1));
      end
      pad_in = v;
   endtask

   // Called just after a falling edge. abort_at >= 0 asserts reset after that trace cycle.
   task automatic run_scan(input bit par, input logic [N-1:0] mask, input bit noisy,
                           input int abort_at);
      obs_t         exp_q[$];
      logic [N-1:0] exp_fail, one;
      logic [5:0]   exp_cp;
      int           done_at, exp_lat;

      exp_fail = mask & (stuck0 | stuck1);
      exp_cp   = (exp_fail != '0) ? 6'h3F : 6'h34;
      if (par) begin
         repeat (S) exp_q.push_back(pack(1, 0, 0, mask, '0, 6'h31));
         repeat (S) exp_q.push_back(pack(1, 0, 0, mask, mask, 6'h32));
         exp_q.push_back(pack(1, 0, 0, '0, '0, 6'h33));
         exp_lat = 2 * S + 1;
      end else begin
         for (int i = 0; i < N; i++) begin
            one = '0;
            one[i] = 1'b1;
            exp_q.push_back(pack(1, 0, 3'(i), '0, '0, 6'h30));
            if (mask[i]) begin
               repeat (S) exp_q.push_back(pack(1, 0, 3'(i), one, '0, 6'h31));
               repeat (S) exp_q.push_back(pack(1, 0, 3'(i), one, one, 6'h32));
               exp_q.push_back(pack(1, 0, 3'(i), '0, '0, 6'h33));
            end
         end
         exp_lat = N + $countones(mask) * (2 * S + 1);
      end
      exp_q.push_back(pack(0, 1, par ? 3'd0 : 3'(N - 1), '0, '0, exp_cp));

      start = 1'b1;
      parallel = par;
      chan_mask = mask;
      drive_pad();
      @(negedge clock);
      start = 1'b0;
      done_at = -1;

      for (int k = 0; k < exp_q.size(); k++) begin
         check_val($sformatf("trace[%0d]", k),
                   64'(pack(busy, done, cur_chan, pull_en, pull_up, checkpoint)), 64'(exp_q[k]));
         if (done && done_at < 0) done_at = k;
         if (k == abort_at) begin
            reset = 1'b1;
            drive_pad();
            @(negedge clock);
            check_val("reset_outputs",
                      64'(pack(busy, done, cur_chan, pull_en, pull_up, checkpoint)), 64'd0);
            check_val("reset_fail_pass", 64'({fail_mask, pass}), 64'd0);
            reset = 1'b0;
            for (int j = 0; j < 3; j++) begin
               drive_pad();
               @(negedge clock);
               check_val("no_done_after_reset", 64'({done, busy}), 64'd0);
            end
            return;
         end
         if (k == exp_q.size() - 1)
            check_val("done_result", 64'({fail_mask, pass}), 64'({exp_fail, exp_fail == '0}));
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            chan_mask = N'($urandom);
            parallel = 1'($urandom_range(0, 1));
         end
         drive_pad();
         @(negedge clock);
      end
      start = 1'b0;
      check_val("done_latency", 64'(done_at), 64'(exp_lat));
      check_val("idle_hold",
                64'({busy, done, pull_en, pull_up, checkpoint, fail_mask, pass}),
                64'({1'b0, 1'b0, N'(0), N'(0), exp_cp, exp_fail, exp_fail == '0}));
      drive_pad();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      parallel = 1'b0;
      chan_mask = '0;
      stuck0 = '0;
      stuck1 = '0;
      pad_in = '0;
      repeat (2) @(negedge clock);
      check_val("reset_state",
                64'({pack(busy, done, cur_chan, pull_en, pull_up, checkpoint), fail_mask, pass}),
                64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_scan(0, 8'h05, 0, -1);               // healthy serial scan
      stuck1 = 8'h04;
      run_scan(0, 8'h05, 0, -1);               // channel 2 stuck high
      stuck1 = '0;
      stuck0 = 8'h20;
      run_scan(1, 8'hF0, 0, -1);               // parallel, channel 5 stuck low
      stuck0 = '0;
      run_scan(0, 8'h00, 0, -1);               // empty mask, serial
      run_scan(1, 8'h00, 0, -1);               // empty mask, parallel
      stuck1 = 8'h04;
      run_scan(0, 8'h05, 0, 17);               // reset in second PU cycle of channel 2
      stuck1 = '0;
      run_scan(0, 8'h05, 0, -1);               // fresh scan after reset
      stuck0 = 8'h02;
      run_scan(0, 8'h5A, 1, -1);               // start/mask/mode noise mid-scan

      for (int r = 0; r < 8; r++) begin
         stuck0 = N'($urandom & $urandom);
         stuck1 = N'($urandom & $urandom) & ~stuck0;
         run_scan(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
